// File: rtl/hamm_decode_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : hamm_decode_pipe_if
// Brief    : Input codeword and output result handshakes of the decoder.
// Revision : 1.0
// ============================================================================
interface hamm_decode_pipe_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] code_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] data_out;
    logic [2:0] syndrome;
    logic       err_det;
    logic       data_err;

    // Driver side: produces codewords and consumes results.
    modport master (
        output in_valid, code_in, out_ready,
        input  in_ready, out_valid, data_out, syndrome, err_det, data_err
    );

    // Decoder side.
    modport slave (
        input  in_valid, code_in, out_ready,
        output in_ready, out_valid, data_out, syndrome, err_det, data_err
    );
endinterface
`default_nettype wire

// File: rtl/hamm_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hamm_decode_pipe
// Brief    : Two-stage Hamming(7,4) decoder with single-bit correction and
//            saturating data/parity error counters.
// Revision : 1.0
// ============================================================================
module hamm_decode_pipe #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    hamm_decode_pipe_if.slave     bus,
    input  wire logic             cnt_clr,
    output logic [CNT_W-1:0]      data_cnt,
    output logic [CNT_W-1:0]      par_cnt
);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             v1_q,       v1_d;
    logic [6:0]       code1_q,    code1_d;
    logic [2:0]       syn1_q,     syn1_d;
    logic             v2_q,       v2_d;
    logic [3:0]       data2_q,    data2_d;
    logic [2:0]       syn2_q,     syn2_d;
    logic             err2_q,     err2_d;
    logic             derr2_q,    derr2_d;
    logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
    logic [CNT_W-1:0] par_cnt_q,  par_cnt_d;

    logic       w_adv1;
    logic       w_adv2;
    logic       w_fire_out;
    logic [2:0] w_syn_in;
    logic [3:0] w_fix_mask;

    assign w_adv2     = !v2_q || bus.out_ready;
    assign w_adv1     = !v1_q || w_adv2;
    assign w_fire_out = v2_q && bus.out_ready;

    // Syndrome of the incoming word; bit i rechecks parity p_i.
    assign w_syn_in[0] = bus.code_in[4] ^ bus.code_in[0] ^ bus.code_in[1] ^ bus.code_in[3];
    assign w_syn_in[1] = bus.code_in[5] ^ bus.code_in[0] ^ bus.code_in[2] ^ bus.code_in[3];
    assign w_syn_in[2] = bus.code_in[6] ^ bus.code_in[1] ^ bus.code_in[2] ^ bus.code_in[3];

    always_comb begin
        w_fix_mask = 4'b0000;
        case (syn1_q)
            3'b011:  w_fix_mask = 4'b0001;
            3'b101:  w_fix_mask = 4'b0010;
            3'b110:  w_fix_mask = 4'b0100;
            3'b111:  w_fix_mask = 4'b1000;
            default: w_fix_mask = 4'b0000;
        endcase
    end

    always_comb begin
        v1_d    = v1_q;
        code1_d = code1_q;
        syn1_d  = syn1_q;
        if (w_adv1) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                code1_d = bus.code_in;
                syn1_d  = w_syn_in;
            end
        end
    end

    // Stage 2 only reloads on a real word, so status holds while the output is idle.
    always_comb begin
        v2_d    = v2_q;
        data2_d = data2_q;
        syn2_d  = syn2_q;
        err2_d  = err2_q;
        derr2_d = derr2_q;
        if (w_adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                data2_d = code1_q[3:0] ^ w_fix_mask;
                syn2_d  = syn1_q;
                err2_d  = |syn1_q;
                derr2_d = (syn1_q[0] & syn1_q[1]) | (syn1_q[0] & syn1_q[2]) |
                          (syn1_q[1] & syn1_q[2]);
            end
        end
    end

    always_comb begin
        data_cnt_d = data_cnt_q;
        par_cnt_d  = par_cnt_q;
        if (cnt_clr) begin
            data_cnt_d = '0;
            par_cnt_d  = '0;
        end else if (w_fire_out) begin
            if (derr2_q && (data_cnt_q != C_CNT_MAX))
                data_cnt_d = data_cnt_q + C_CNT_ONE;
            if (err2_q && !derr2_q && (par_cnt_q != C_CNT_MAX))
                par_cnt_d = par_cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            code1_q    <= '0;
            syn1_q     <= '0;
            v2_q       <= 1'b0;
            data2_q    <= '0;
            syn2_q     <= '0;
            err2_q     <= 1'b0;
            derr2_q    <= 1'b0;
            data_cnt_q <= '0;
            par_cnt_q  <= '0;
        end else begin
            v1_q       <= v1_d;
            code1_q    <= code1_d;
            syn1_q     <= syn1_d;
            v2_q       <= v2_d;
            data2_q    <= data2_d;
            syn2_q     <= syn2_d;
            err2_q     <= err2_d;
            derr2_q    <= derr2_d;
            data_cnt_q <= data_cnt_d;
            par_cnt_q  <= par_cnt_d;
        end
    end

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = v2_q;
    assign bus.data_out  = data2_q;
    assign bus.syndrome  = syn2_q;
    assign bus.err_det   = err2_q;
    assign bus.data_err  = derr2_q;
    assign data_cnt      = data_cnt_q;
    assign par_cnt       = par_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_hamm_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamm_decode_pipe
// Brief    : Directed self-checking bench for the Hamming(7,4) decoder pipe.
// Revision : 1.0
// ============================================================================
module tb_hamm_decode_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cnt_clr;
    logic       cnt_clr2;
    logic [7:0] data_cnt;
    logic [7:0] par_cnt;
    logic [1:0] data_cnt2;
    logic [1:0] par_cnt2;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_dcnt = 0;
    int exp_pcnt = 0;

    hamm_decode_pipe_if bus ();
    hamm_decode_pipe_if bus2 ();

    hamm_decode_pipe #(.CNT_W(8)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .cnt_clr  (cnt_clr),
        .data_cnt (data_cnt),
        .par_cnt  (par_cnt)
    );

    hamm_decode_pipe #(.CNT_W(2)) u_dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus2),
        .cnt_clr  (cnt_clr2),
        .data_cnt (data_cnt2),
        .par_cnt  (par_cnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one word for a single cycle; returns at the negedge after edge N+1.
    task automatic push_word(input logic [6:0] code);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.code_in  = code;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cnt_clr = 1'b0;  cnt_clr2 = 1'b0;
        bus.in_valid = 1'b0;  bus.code_in = '0;  bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.code_in = '0; bus2.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        n_tests++;
        if (data_cnt !== 8'd0 || par_cnt !== 8'd0 || bus.data_out !== 4'h0 || bus.syndrome !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_regs: data_cnt=%0d par_cnt=%0d data_out=%h syndrome=%b, want all 0",
                     data_cnt, par_cnt, bus.data_out, bus.syndrome);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean();
        bus.out_ready = 1'b1;
        push_word(7'h1B);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_latency_early: out_valid=%b at N+1, want 0", bus.out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.data_out !== 4'hB || bus.syndrome !== 3'b000 ||
            bus.err_det !== 1'b0 || bus.data_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_word: valid=%b data=%h syn=%b err=%b derr=%b, want 1 b 000 0 0",
                     bus.out_valid, bus.data_out, bus.syndrome, bus.err_det, bus.data_err);
        end
        @(negedge clk);
        n_tests++;
        if (data_cnt !== 8'(exp_dcnt) || par_cnt !== 8'(exp_pcnt) || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_counters: data_cnt=%0d par_cnt=%0d valid=%b, want %0d %0d 0",
                     data_cnt, par_cnt, bus.out_valid, exp_dcnt, exp_pcnt);
        end
    endtask

    task automatic test_data_err();
        logic [6:0] codes [2] = '{7'h1A, 7'h13};
        logic [2:0] syns  [2] = '{3'b011, 3'b111};
        for (int i = 0; i < 2; i++) begin
            push_word(codes[i]);
            @(negedge clk);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.data_out !== 4'hB || bus.syndrome !== syns[i] ||
                bus.err_det !== 1'b1 || bus.data_err !== 1'b1) begin
                n_fail++;
                $display("FAIL data_err_%0d: valid=%b data=%h syn=%b err=%b derr=%b, want 1 b %b 1 1",
                         i, bus.out_valid, bus.data_out, bus.syndrome, bus.err_det, bus.data_err, syns[i]);
            end
            exp_dcnt++;
            @(negedge clk);
            n_tests++;
            if (data_cnt !== 8'(exp_dcnt) || par_cnt !== 8'(exp_pcnt)) begin
                n_fail++;
                $display("FAIL data_err_cnt_%0d: data_cnt=%0d par_cnt=%0d, want %0d %0d",
                         i, data_cnt, par_cnt, exp_dcnt, exp_pcnt);
            end
        end
    endtask

    task automatic test_par_err();
        logic [6:0] codes [2] = '{7'h0B, 7'h5B};
        logic [2:0] syns  [2] = '{3'b001, 3'b100};
        for (int i = 0; i < 2; i++) begin
            push_word(codes[i]);
            @(negedge clk);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.data_out !== 4'hB || bus.syndrome !== syns[i] ||
                bus.err_det !== 1'b1 || bus.data_err !== 1'b0) begin
                n_fail++;
                $display("FAIL par_err_%0d: valid=%b data=%h syn=%b err=%b derr=%b, want 1 b %b 1 0",
                         i, bus.out_valid, bus.data_out, bus.syndrome, bus.err_det, bus.data_err, syns[i]);
            end
            exp_pcnt++;
            @(negedge clk);
            n_tests++;
            if (data_cnt !== 8'(exp_dcnt) || par_cnt !== 8'(exp_pcnt)) begin
                n_fail++;
                $display("FAIL par_err_cnt_%0d: data_cnt=%0d par_cnt=%0d, want %0d %0d",
                         i, data_cnt, par_cnt, exp_dcnt, exp_pcnt);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] codes [5] = '{7'h31, 7'h52, 7'h55, 7'h7F, 7'h1D};
        logic [3:0] datas [5] = '{4'h1, 4'h2, 4'h5, 4'hF, 4'hC};
        int pi = 0;
        int ci = 0;
        int stall_acc = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 6);
            bus.in_valid  = (pi < 5);
            bus.code_in   = (pi < 5) ? codes[pi] : 7'h00;
            #1;
            if (cyc == 4) begin
                n_tests++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.data_out !== 4'h1) begin
                    n_fail++;
                    $display("FAIL bp_stall_hold: in_ready=%b valid=%b data=%h, want 0 1 1",
                             bus.in_ready, bus.out_valid, bus.data_out);
                end
            end
            if (!bus.out_ready && bus.in_valid && bus.in_ready) stall_acc++;
            if (bus.out_valid && bus.out_ready) begin
                n_tests++;
                if (ci >= 5 || bus.data_out !== datas[ci]) begin
                    n_fail++;
                    $display("FAIL bp_order_%0d: data=%h, want %h", ci, bus.data_out,
                             (ci < 5) ? datas[ci] : 4'hx);
                end
                ci++;
            end
            if (bus.in_valid && bus.in_ready) pi++;
        end
        bus.in_valid = 1'b0;
        exp_dcnt++;
        n_tests++;
        if (stall_acc != 2 || ci != 5 || pi != 5) begin
            n_fail++;
            $display("FAIL bp_counts: stall_accepts=%0d delivered=%0d sent=%0d, want 2 5 5", stall_acc, ci, pi);
        end
        n_tests++;
        if (data_cnt !== 8'(exp_dcnt) || par_cnt !== 8'(exp_pcnt)) begin
            n_fail++;
            $display("FAIL bp_cnt: data_cnt=%0d par_cnt=%0d, want %0d %0d", data_cnt, par_cnt, exp_dcnt, exp_pcnt);
        end
    endtask

    task automatic test_counters();
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1;
            bus2.code_in  = 7'h1A;
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (data_cnt2 !== 2'd3 || par_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL cnt_saturate: data_cnt=%0d par_cnt=%0d, want 3 0", data_cnt2, par_cnt2);
        end
        cnt_clr2 = 1'b1;
        @(negedge clk);
        cnt_clr2 = 1'b0;
        n_tests++;
        if (data_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL cnt_clear: data_cnt=%0d, want 0", data_cnt2);
        end
        // One counted word, then a second one whose handshake coincides with the clear.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1;
            bus2.code_in  = 7'h1A;
            @(negedge clk);
            bus2.in_valid = 1'b0;
            @(negedge clk);
            cnt_clr2 = (k == 1);
            @(negedge clk);
            cnt_clr2 = 1'b0;
            n_tests++;
            if (data_cnt2 !== ((k == 1) ? 2'd0 : 2'd1)) begin
                n_fail++;
                $display("FAIL cnt_clr_vs_inc_%0d: data_cnt=%0d, want %0d", k, data_cnt2, (k == 1) ? 0 : 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.code_in  = 7'h31;
        @(negedge clk);
        bus.code_in  = 7'h52;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || data_cnt !== 8'(exp_dcnt)) begin
            n_fail++;
            $display("FAIL rst_pre_full: valid=%b in_ready=%b data_cnt=%0d, want 1 0 %0d",
                     bus.out_valid, bus.in_ready, data_cnt, exp_dcnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_dcnt = 0;
        exp_pcnt = 0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || data_cnt !== 8'd0 || par_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: valid=%b data_cnt=%0d par_cnt=%0d in_ready=%b, want 0 0 0 1",
                     bus.out_valid, data_cnt, par_cnt, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        push_word(7'h64);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after_early: out_valid=%b at N+1, want 0", bus.out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.data_out !== 4'h4 || bus.syndrome !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_after_word: valid=%b data=%h syn=%b, want 1 4 000",
                     bus.out_valid, bus.data_out, bus.syndrome);
        end
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_replay: out_valid=%b, want 0", bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_data_err();
        test_par_err();
        test_backpressure();
        test_counters();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
